// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - pixel-plot receiver: range check, request FIFO, granted framebuffer writes
module plot_sink #(
    parameter int DEPTH = 8,
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        clear,
    input  logic        mem_grant,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_wren,
    output logic        busy,
    output logic [5:0]  fifo_level,
    output logic        overflow,
    output logic [7:0]  dropped_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [7:0] V_LIM = 8'(V_RES);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [17:0]    fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [17:0]    head;
    logic [14:0]    pixel_addr;
    logic           in_range;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           lost;
    logic           drop;

    assign in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    assign full     = (fifo_level == 6'(DEPTH));
    assign empty    = (fifo_level == 6'd0);

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign push = plot && in_range && (!full || pop);
    assign lost = plot && in_range && full && !pop;
    assign drop = (plot && !in_range) || lost;

    assign head       = fifo_mem[rd_ptr];
    assign pixel_addr = 15'(head[9:3]) * 15'(H_RES) + 15'(head[17:10]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Both states pop whenever an entry is waiting and the port is granted.
    always_comb begin
        state_nxt = IDLE;
        pop       = 1'b0;
        case (state)
            IDLE, WRITE: begin
                if (!empty && mem_grant) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_wren = (state == WRITE);
    assign busy     = (fifo_level != 6'd0) || mem_wren;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {x, y, colour};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 6'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 6'd1;
                2'b01:   fifo_level <= fifo_level - 6'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= 15'd0;
            mem_data <= 3'd0;
        end else if (pop) begin
            mem_addr <= pixel_addr;
            mem_data <= head[2:0];
        end
    end

    // clear takes priority over a drop on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow      <= 1'b0;
            dropped_count <= 8'd0;
        end else if (clear) begin
            overflow      <= 1'b0;
            dropped_count <= 8'd0;
        end else begin
            if (lost) begin
                overflow <= 1'b1;
            end
            if (drop && dropped_count != 8'hFF) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - self-checking bench for plot_sink
module tb_plot_sink;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        clear;
    logic        mem_grant;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        busy;
    logic [5:0]  fifo_level;
    logic        overflow;
    logic [7:0]  dropped_count;

    plot_sink #(.DEPTH(8), .H_RES(160), .V_RES(120)) dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
        .clear(clear), .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .busy(busy), .fifo_level(fifo_level), .overflow(overflow),
        .dropped_count(dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        bit exp_drop;
    } vec_t;

    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    int   exp_dropped = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drives one plot for a single edge; accepted pixels go to the scoreboard.
    task automatic plot_px(input int px, input int py, input int pc, input bit accept);
        wr_t w;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        plot   = 1'b1;
        if (accept) begin
            w.addr = py * 160 + px;
            w.data = pc;
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        plot = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && mem_wren) begin
            wr_t e;
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=addr %0d expected=no write", mem_addr);
            end else begin
                e = sb.pop_front();
                if (int'(mem_addr) != e.addr || int'(mem_data) != e.data) begin
                    errors++;
                    $display("FAIL write_data actual=addr %0d data %0d expected=addr %0d data %0d",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   wr_before;

        vecs[0] = '{160, 0,   1, 1'b1};
        vecs[1] = '{0,   120, 2, 1'b1};
        vecs[2] = '{159, 119, 7, 1'b0};
        vecs[3] = '{0,   0,   1, 1'b0};
        vecs[4] = '{255, 127, 6, 1'b1};
        vecs[5] = '{10,  20,  3, 1'b0};

        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        clear = 1'b0; mem_grant = 1'b0;
        #1;
        chk("reset_wren", int'(mem_wren), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_dropped", int'(dropped_count), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // T1 single pixel latency
        mem_grant = 1'b1;
        plot_px(79, 63, 5, 1'b1);
        @(negedge clk);
        chk("t1_level_after_push", int'(fifo_level), 1);
        chk("t1_wren_early", int'(mem_wren), 0);
        @(negedge clk);
        chk("t1_wren", int'(mem_wren), 1);
        chk("t1_addr", int'(mem_addr), 10159);
        chk("t1_data", int'(mem_data), 5);
        @(negedge clk);
        chk("t1_busy_done", int'(busy), 0);

        // T2 range checks, table driven
        for (int i = 0; i < 6; i++) begin
            plot_px(vecs[i].x, vecs[i].y, vecs[i].c, !vecs[i].exp_drop);
            if (vecs[i].exp_drop) exp_dropped++;
            @(negedge clk);
            chk($sformatf("t2_dropped_%0d", i), int'(dropped_count), exp_dropped);
        end
        drain("t2");
        chk("t2_overflow", int'(overflow), 0);

        // T3 stall then burst
        mem_grant = 1'b0;
        wr_before = wr_count;
        for (int i = 0; i < 8; i++) plot_px(i, 0, i, 1'b1);
        @(negedge clk);
        chk("t3_level_full", int'(fifo_level), 8);
        chk("t3_no_writes", wr_count - wr_before, 0);
        #1 mem_grant = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t3_burst_%0d", i), int'(mem_wren), 1);
        end
        @(negedge clk);
        chk("t3_burst_end", int'(mem_wren), 0);
        chk("t3_level_empty", int'(fifo_level), 0);

        // T4 overflow then clear
        mem_grant = 1'b0;
        for (int i = 0; i < 8; i++) plot_px(i, 1, 7 - i, 1'b1);
        plot_px(5, 5, 2, 1'b0);
        exp_dropped++;
        @(negedge clk);
        chk("t4_overflow", int'(overflow), 1);
        chk("t4_dropped", int'(dropped_count), exp_dropped);
        chk("t4_level", int'(fifo_level), 8);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_dropped = 0;
        @(negedge clk);
        chk("t4_clear_overflow", int'(overflow), 0);
        chk("t4_clear_dropped", int'(dropped_count), 0);

        // T5 full FIFO with pop and push on the same edge
        mem_grant = 1'b1;
        plot_px(9, 9, 4, 1'b1);
        @(negedge clk);
        chk("t5_level", int'(fifo_level), 8);
        chk("t5_dropped", int'(dropped_count), 0);
        chk("t5_overflow", int'(overflow), 0);
        chk("t5_wren", int'(mem_wren), 1);
        drain("t5");

        // T6 reset during a burst
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) plot_px(20 + i, 30, i, 1'b1);
        mem_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_wren_before", int'(mem_wren), 1);
        chk("t6_level_before", int'(fifo_level), 4);
        #2 reset = 1'b1;
        #1;
        chk("t6_reset_wren", int'(mem_wren), 0);
        chk("t6_reset_level", int'(fifo_level), 0);
        chk("t6_reset_busy", int'(busy), 0);
        chk("t6_reset_addr", int'(mem_addr), 0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        wr_before = wr_count;
        repeat (10) @(negedge clk);
        chk("t6_no_replay", wr_count - wr_before, 0);
        plot_px(3, 4, 6, 1'b1);
        drain("t6");
        chk("t6_new_write", wr_count - wr_before, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
